// File: rtl/score_display.sv
// Two-player score keeper: latches goal edges, commits them once per frame, detects the match
// win and renders both scores as 7-segment digits in the top corners of the frame.
module score_display #(
   parameter int          HRES         = 1280,
   parameter int          VRES         = 720,
   parameter int          WIN_SCORE    = 5,
   parameter int          DIGIT_W      = 40,
   parameter int          DIGIT_H      = 80,
   parameter int          SEG_T        = 8,
   parameter int          DIGIT_MARGIN = 40,
   parameter int          DIGIT_Y      = 40,
   parameter int          BLINK_FRAMES = 32,
   parameter logic [23:0] COLOR        = 24'hFFFFFF
) (
   input  logic                    pixel_clk,
   input  logic                    rst,
   input  logic                    fsync,
   input  logic signed [11:0]      hpos,
   input  logic signed [11:0]      vpos,
   input  logic [1:0]              increment_score,
   input  logic                    new_match,
   output logic [3:0]              score_p1,
   output logic [3:0]              score_p2,
   output logic [1:0]              winner,
   output logic                    match_over,
   output logic [2:0][7:0]         pixel,
   output logic                    active
);

   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [3:0]         WIN_C  = 4'(WIN_SCORE);
   localparam logic [BW-1:0]      BLINK_MAX = BW'(BLINK_FRAMES - 1);
   localparam logic signed [12:0] W_C    = 13'(DIGIT_W);
   localparam logic signed [12:0] H_C    = 13'(DIGIT_H);
   localparam logic signed [12:0] T_C    = 13'(SEG_T);
   localparam logic signed [12:0] M_C    = 13'(DIGIT_H / 2);
   localparam logic signed [12:0] G_LO   = 13'(DIGIT_H / 2 - SEG_T / 2);
   localparam logic signed [12:0] G_HI   = 13'(DIGIT_H / 2 - SEG_T / 2 + SEG_T);
   localparam logic signed [12:0] Y0_C   = 13'(DIGIT_Y);
   localparam logic signed [12:0] P1_X0  = 13'(DIGIT_MARGIN);
   localparam logic signed [12:0] P2_X0  = 13'(HRES - DIGIT_MARGIN - DIGIT_W);
   localparam logic signed [12:0] HRES_C = 13'(HRES);
   localparam logic signed [12:0] VRES_C = 13'(VRES);
   localparam logic signed [12:0] ZERO_C = 13'sd0;

   typedef enum logic [0:0] {S_PLAY = 1'b0, S_WIN = 1'b1} state_t;

   state_t         state_q, state_d;
   logic [1:0]     inc_prev_q, inc_prev_d;
   logic [1:0]     pend_q, pend_d;
   logic [3:0]     score_p1_q, score_p1_d;
   logic [3:0]     score_p2_q, score_p2_d;
   logic [1:0]     winner_q, winner_d;
   logic [BW-1:0]  blink_q, blink_d;
   logic           phase_q, phase_d;

   logic [1:0]     rise_s;
   logic [1:0]     pend_eff_s;
   logic [3:0]     sum_p1_s, sum_p2_s;
   logic           hit_p1_s, hit_p2_s;
   logic signed [12:0] x_s, y_s;
   logic           p1_vis_s, p2_vis_s, on_screen_s, active_s;

   function automatic logic [3:0] sat_add(input logic [3:0] score, input logic inc);
      logic [4:0] s;
      s = {1'b0, score} + {4'b0000, inc};
      if (s > {1'b0, WIN_C}) begin
         return WIN_C;
      end else begin
         return s[3:0];
      end
   endfunction

   // Segment map ordered {a,b,c,d,e,f,g}.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1111110;
         4'd1:    return 7'b0110000;
         4'd2:    return 7'b1101101;
         4'd3:    return 7'b1111001;
         4'd4:    return 7'b0110011;
         4'd5:    return 7'b1011011;
         4'd6:    return 7'b1011111;
         4'd7:    return 7'b1110000;
         4'd8:    return 7'b1111111;
         4'd9:    return 7'b1111011;
         default: return 7'b0000000;
      endcase
   endfunction

   function automatic logic digit_lit(input logic signed [12:0] x, input logic signed [12:0] y,
                                      input logic signed [12:0] x0, input logic [3:0] d);
      logic signed [12:0] dx, dy;
      logic [6:0] hit;
      logic in_box, top, left, right;
      dx     = x - x0;
      dy     = y - Y0_C;
      in_box = (dx >= ZERO_C) && (dx < W_C) && (dy >= ZERO_C) && (dy < H_C);
      top    = dy < M_C;
      left   = dx < T_C;
      right  = dx >= (W_C - T_C);
      hit    = {dy < T_C, right & top, right & ~top, dy >= (H_C - T_C),
                left & ~top, left & top, (dy >= G_LO) && (dy < G_HI)};
      return in_box & (|(hit & seg7(d)));
   endfunction

   // State registers, including the previous increment level used for edge detection.
   always_ff @(posedge pixel_clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_PLAY;
         inc_prev_q <= 2'b00;
         pend_q     <= 2'b00;
         score_p1_q <= 4'd0;
         score_p2_q <= 4'd0;
         winner_q   <= 2'b00;
         blink_q    <= '0;
         phase_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         inc_prev_q <= inc_prev_d;
         pend_q     <= pend_d;
         score_p1_q <= score_p1_d;
         score_p2_q <= score_p2_d;
         winner_q   <= winner_d;
         blink_q    <= blink_d;
         phase_q    <= phase_d;
      end
   end

   // Next-state: goal latching, per-frame commit, win detection and winner blink timing.
   always_comb begin
      state_d    = state_q;
      inc_prev_d = increment_score;
      pend_d     = pend_q;
      score_p1_d = score_p1_q;
      score_p2_d = score_p2_q;
      winner_d   = winner_q;
      blink_d    = blink_q;
      phase_d    = phase_q;
      rise_s     = increment_score & ~inc_prev_q;
      pend_eff_s = pend_q | rise_s;
      sum_p1_s   = sat_add(score_p1_q, pend_eff_s[0]);
      sum_p2_s   = sat_add(score_p2_q, pend_eff_s[1]);
      hit_p1_s   = (sum_p1_s == WIN_C);
      hit_p2_s   = (sum_p2_s == WIN_C);
      if (new_match) begin
         state_d    = S_PLAY;
         pend_d     = 2'b00;
         score_p1_d = 4'd0;
         score_p2_d = 4'd0;
         winner_d   = 2'b00;
         blink_d    = '0;
         phase_d    = 1'b1;
      end else begin
         case (state_q)
            S_PLAY: begin
               if (fsync) begin
                  score_p1_d = sum_p1_s;
                  score_p2_d = sum_p2_s;
                  pend_d     = 2'b00;
                  if (hit_p1_s || hit_p2_s) begin
                     state_d  = S_WIN;
                     winner_d = {hit_p2_s, hit_p1_s};
                  end else begin
                     state_d  = S_PLAY;
                  end
               end else begin
                  pend_d = pend_eff_s;
               end
            end
            S_WIN: begin
               pend_d = 2'b00;
               if (fsync) begin
                  if (blink_q == BLINK_MAX) begin
                     blink_d = '0;
                     phase_d = ~phase_q;
                  end else begin
                     blink_d = blink_q + 1'b1;
                  end
               end else begin
                  blink_d = blink_q;
               end
            end
            default: begin
               state_d = S_PLAY;
            end
         endcase
      end
   end

   assign x_s = {hpos[11], hpos};
   assign y_s = {vpos[11], vpos};

   // Pixel layer: zero-latency lookup of the current position against both digits.
   always_comb begin
      active_s    = 1'b0;
      on_screen_s = (x_s >= ZERO_C) && (y_s >= ZERO_C) && (x_s < HRES_C) && (y_s < VRES_C);
      p1_vis_s    = !((state_q == S_WIN) && winner_q[0] && !phase_q);
      p2_vis_s    = !((state_q == S_WIN) && winner_q[1] && !phase_q);
      if (on_screen_s) begin
         active_s = (p1_vis_s & digit_lit(x_s, y_s, P1_X0, score_p1_q)) |
                    (p2_vis_s & digit_lit(x_s, y_s, P2_X0, score_p2_q));
      end else begin
         active_s = 1'b0;
      end
   end

   assign active     = active_s;
   assign pixel      = active_s ? COLOR : 24'h000000;
   assign score_p1   = score_p1_q;
   assign score_p2   = score_p2_q;
   assign winner     = winner_q;
   assign match_over = (state_q == S_WIN);

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display: score/winner/blink model plus rectangle-based digit
// renderer compared every cycle, with literal spot checks at the notable moments.
module tb_score_display;

   logic              pixel_clk = 1'b0;
   logic              rst = 1'b1;
   logic              fsync = 1'b0;
   logic              new_match = 1'b0;
   logic signed [11:0] hpos = 12'sd0;
   logic signed [11:0] vpos = 12'sd0;
   logic [1:0]        increment_score = 2'b00;
   logic [3:0]        score_p1, score_p2;
   logic [1:0]        winner;
   logic              match_over;
   logic [2:0][7:0]   pixel;
   logic              active;

   score_display dut (
      .pixel_clk(pixel_clk), .rst(rst), .fsync(fsync), .hpos(hpos), .vpos(vpos),
      .increment_score(increment_score), .new_match(new_match),
      .score_p1(score_p1), .score_p2(score_p2), .winner(winner), .match_over(match_over),
      .pixel(pixel), .active(active)
   );

   always #5 pixel_clk = ~pixel_clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: plain integer scores, goal flags and a count of fsyncs seen since the win.
   localparam logic [6:0] GLYPH [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                         7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
   int         m_s1 = 0, m_s2 = 0, m_wf = 0;
   logic [1:0] m_pend = 2'b00, m_prev = 2'b00, m_win = 2'b00;
   logic       m_over = 1'b0;
   logic [1:0] m_p;
   int         m_n1, m_n2;

   assign m_p  = m_pend | (increment_score & ~m_prev);
   assign m_n1 = m_s1 + int'(m_p[0]);
   assign m_n2 = m_s2 + int'(m_p[1]);

   always @(posedge pixel_clk or posedge rst) begin
      if (rst) begin
         m_s1 <= 0; m_s2 <= 0; m_wf <= 0;
         m_pend <= 2'b00; m_prev <= 2'b00; m_win <= 2'b00; m_over <= 1'b0;
      end else begin
         m_prev <= increment_score;
         if (new_match) begin
            m_s1 <= 0; m_s2 <= 0; m_wf <= 0;
            m_pend <= 2'b00; m_win <= 2'b00; m_over <= 1'b0;
         end else if (!m_over) begin
            if (fsync) begin
               m_s1   <= m_n1;
               m_s2   <= m_n2;
               m_pend <= 2'b00;
               if (m_n1 == 5 || m_n2 == 5) begin
                  m_over <= 1'b1;
                  m_win  <= {m_n2 == 5, m_n1 == 5};
               end
            end else begin
               m_pend <= m_p;
            end
         end else if (fsync) begin
            m_wf <= m_wf + 1;
         end
      end
   end

   function automatic bit m_lit(input int h, input int v);
      if (h < 0 || v < 0 || h >= 1280 || v >= 720) return 1'b0;
      for (int pl = 0; pl < 2; pl++) begin
         int x0 = (pl == 1) ? 1200 : 40;
         int d  = (pl == 1) ? m_s2 : m_s1;
         bit vis = !(m_over && m_win[pl] && (((m_wf / 32) % 2) == 1));
         int dx = h - x0;
         int dy = v - 40;
         logic [6:0] g = (d >= 0 && d <= 9) ? GLYPH[d] : 7'h00;
         if (vis && dx >= 0 && dx < 40 && dy >= 0 && dy < 80) begin
            if (g[6] && dy < 8) return 1'b1;
            if (g[5] && dx >= 32 && dy < 40) return 1'b1;
            if (g[4] && dx >= 32 && dy >= 40) return 1'b1;
            if (g[3] && dy >= 72) return 1'b1;
            if (g[2] && dx < 8 && dy >= 40) return 1'b1;
            if (g[1] && dx < 8 && dy < 40) return 1'b1;
            if (g[0] && dy >= 36 && dy < 44) return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   // Compare process: every outputs-stable (falling) edge.
   always @(negedge pixel_clk) begin
      bit lit;
      lit = m_lit(int'(hpos), int'(vpos));
      chk("score_p1", 32'(score_p1), 32'(m_s1));
      chk("score_p2", 32'(score_p2), 32'(m_s2));
      chk("winner", 32'(winner), 32'(m_win));
      chk("match_over", 32'(match_over), 32'(m_over));
      chk("active", 32'(active), 32'(lit));
      chk("pixel", 32'(pixel), lit ? 32'h00FFFFFF : 32'h0);
   end

   int pt_h [24];
   int pt_v [24];
   int k = 0;

   task automatic cyc(input logic fs, input logic [1:0] inc, input logic nm);
      @(posedge pixel_clk);
      #2;
      fsync           = fs;
      increment_score = inc;
      new_match       = nm;
      hpos            = 12'(pt_h[k % 24]);
      vpos            = 12'(pt_v[k % 24]);
      k++;
   endtask

   task automatic pnt(input logic [1:0] inc);
      cyc(1'b0, inc, 1'b0);
      cyc(1'b0, 2'b00, 1'b0);
      cyc(1'b1, 2'b00, 1'b0);
      cyc(1'b0, 2'b00, 1'b0);
   endtask

   task automatic frames(input int n);
      repeat (n) begin
         cyc(1'b1, 2'b00, 1'b0);
         cyc(1'b0, 2'b00, 1'b0);
      end
   endtask

   task automatic probe(input string name, input int h, input int v, input logic exp);
      hpos = 12'(h);
      vpos = 12'(v);
      #1;
      chk(name, 32'(active), 32'(exp));
   endtask

   initial begin
      int rdx [11] = '{20, 36, 36, 20, 4, 4, 20, 20, 20, -1, 40};
      int rdy [11] = '{4, 20, 60, 76, 60, 20, 40, 20, 60, 4, 4};
      for (int i = 0; i < 11; i++) begin
         pt_h[i]      = 40 + rdx[i];   pt_v[i]      = 40 + rdy[i];
         pt_h[i + 11] = 1200 + rdx[i]; pt_v[i + 11] = 40 + rdy[i];
      end
      pt_h[22] = -5; pt_v[22] = -5;
      pt_h[23] = -1; pt_v[23] = 50;

      // Reset and the idle "0 0" frame.
      repeat (3) cyc(1'b0, 2'b00, 1'b0);
      rst = 1'b0;
      cyc(1'b0, 2'b00, 1'b0);
      #1;
      chk("t1_score_p1", 32'(score_p1), 32'd0);
      probe("t1_corner_on", 44, 44, 1'b1);
      chk("t1_pixel_colour", 32'(pixel), 32'h00FFFFFF);
      probe("t1_center_off", 60, 80, 1'b0);

      // Two P1 edges in one frame commit as a single point.
      cyc(1'b0, 2'b01, 1'b0);
      cyc(1'b0, 2'b00, 1'b0);
      cyc(1'b0, 2'b01, 1'b0);
      cyc(1'b0, 2'b00, 1'b0);
      #1 chk("t2_before_fsync", 32'(score_p1), 32'd0);
      cyc(1'b1, 2'b00, 1'b0);
      cyc(1'b0, 2'b00, 1'b0);
      #1 chk("t2_after_fsync", 32'(score_p1), 32'd1);
      probe("t2_one_seg_b", 76, 60, 1'b1);
      probe("t2_one_seg_f", 44, 60, 1'b0);

      // Edge coincident with fsync is committed at that fsync.
      cyc(1'b1, 2'b01, 1'b0);
      cyc(1'b0, 2'b00, 1'b0);
      #1 chk("t3_same_cycle", 32'(score_p1), 32'd2);

      // Tie at WIN_SCORE, then frozen.
      pnt(2'b11); pnt(2'b11); pnt(2'b10); pnt(2'b10);
      #1 chk("t4_p2_four", 32'(score_p2), 32'd4);
      pnt(2'b11);
      #1 chk("t4_winner_tie", 32'(winner), 32'd3);
      chk("t4_over", 32'(match_over), 32'd1);
      pnt(2'b11); pnt(2'b01);
      #1 chk("t4_frozen_p1", 32'(score_p1), 32'd5);
      cyc(1'b0, 2'b00, 1'b1);
      cyc(1'b0, 2'b00, 1'b0);
      #1 chk("t4_cleared", 32'(score_p1), 32'd0);

      // P1 wins 5-2; winner digit blinks with a 32-frame half period.
      pnt(2'b11); pnt(2'b11); pnt(2'b01); pnt(2'b01); pnt(2'b01);
      #1 chk("t5_winner_p1", 32'(winner), 32'd1);
      frames(31);
      probe("t5_on_31", 60, 44, 1'b1);
      frames(1);
      probe("t5_off_32", 60, 44, 1'b0);
      probe("t5_loser_steady", 1220, 44, 1'b1);
      frames(32);
      probe("t5_on_64", 60, 44, 1'b1);
      cyc(1'b1, 2'b00, 1'b1);
      cyc(1'b0, 2'b00, 1'b0);
      #1 chk("t5_newmatch_p1", 32'(score_p1), 32'd0);
      chk("t5_newmatch_winner", 32'(winner), 32'd0);
      chk("t5_newmatch_over", 32'(match_over), 32'd0);

      // Asynchronous reset mid-frame with a pending point.
      pnt(2'b01);
      cyc(1'b0, 2'b10, 1'b0);
      cyc(1'b0, 2'b00, 1'b0);
      #1 rst = 1'b1;
      #1 chk("t6_rst_now", 32'(score_p1), 32'd0);
      cyc(1'b0, 2'b00, 1'b0);
      rst = 1'b0;
      cyc(1'b1, 2'b00, 1'b0);
      cyc(1'b0, 2'b00, 1'b0);
      #1 chk("t6_pend_lost", 32'(score_p2), 32'd0);
      cyc(1'b0, 2'b00, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
